seq_divider_nr: RTL
===================

# seq_divider_nr

Sequential radix-2 non-restoring integer divider producing quotient and remainder one bit per clock. It is the division counterpart of the team's sequential Booth multiplier and shares its start/done handshake, so both units plug into the same arithmetic test harness and controller. Signed (two's complement, truncating toward zero) or unsigned operation is selected at compile time.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a division; sampled on rising edge while not busy
- dividend  input  WIDTH  dividend, captured on accepted start
- divisor  input  WIDTH  divisor, captured on accepted start
- quotient  output  WIDTH  registered quotient, valid while done=1
- remainder  output  WIDTH  registered remainder, valid while done=1
- busy  output  1  high from accepted start until result is written
- done  output  1  level; high once a result is written, until the next accepted start or reset
- div_by_zero  output  1  high with done when captured divisor was 0

## Operation
- States: IDLE, CALC, FIX, DONE. Reset -> IDLE; all outputs and internal registers 0.
- IDLE/DONE + start=1: capture operands, clear done and div_by_zero, set busy. divisor!=0 -> CALC with count=WIDTH; divisor==0 -> FIX directly.
- Signed build: take magnitudes |dividend|, |divisor| as WIDTH-bit unsigned values (most-negative value maps to 2^(WIDTH-1)); record qneg = sign(dividend) XOR sign(divisor), rneg = sign(dividend).
- CALC, one iteration per edge: shift {R,Q} left 1 (R is WIDTH+1-bit signed partial remainder, Q shifts in dividend magnitude); if R (before shift) >= 0 then R = R - D, else R = R + D; Q[0] = NOT sign(new R). count decrements; count reaching 0 -> FIX.
- FIX (one edge): if R < 0, R = R + D. Apply sign: quotient = qneg ? -Q : Q; remainder = rneg ? -R[WIDTH-1:0] : R[WIDTH-1:0]. Register outputs, busy=0, done=1 -> DONE.
- Divide by zero: FIX writes quotient = all ones, remainder = dividend (as captured), div_by_zero=1, done=1.
- Overflow (signed, most-negative / -1): quotient wraps to most-negative value, remainder 0; no flag.
- start while busy: ignored, no effect on operation in progress.
- Outputs quotient/remainder hold their last values until the next FIX edge; they are not cleared by start.

## Timing
- Accepted start on edge E0. Normal division: iterations on E1..E_WIDTH, FIX on E_(WIDTH+1); done high after E_(WIDTH+1) (WIDTH+1 cycles after start edge; 9 for WIDTH=8).
- Divide by zero: FIX on E1; done high after E1.
- busy high after E0 through the FIX edge; low in the same cycle done rises.
- Back-to-back: start may be asserted in the first cycle done is high; accepted on the next edge, done drops after that edge.
- rst asserted at any time, including mid-CALC: immediate return to IDLE, busy/done/div_by_zero=0, quotient/remainder=0; start held through reset deassertion is sampled on the first edge after release.

## Configuration
- SEQ_DIV_SIGNED_EN defined: signed two's complement operation as above (quotient truncates toward zero, remainder takes dividend's sign).
- Not defined: pure unsigned operation; magnitude/sign-fix logic removed, operands used directly, qneg=rneg=0. Latency unchanged.

## Test plan
- Signed 100 / 7: start one cycle -> done after 9 edges, quotient=14, remainder=2, div_by_zero=0; busy high exactly 9 cycles.
- Signed sign combinations: -100/7 -> q=-14 r=-2; 100/-7 -> q=-14 r=2; -100/-7 -> q=14 r=-2.
- Signed -128 / -1 -> q=-128 (0x80) r=0; -128 / 1 -> q=-128 r=0; unsigned build 200/7 -> q=28 r=4.
- 55 / 0 -> done after 1 edge, quotient=0xFF, remainder=55, div_by_zero=1; following 9/3 clears div_by_zero on start, returns q=3 r=0.
- start pulsed again at cycle 4 of a running 100/7 -> ignored, result q=14 r=2 at unchanged time; start in first done cycle -> second result 9 cycles later.
- rst asserted at cycle 5 of a division -> all outputs 0 immediately, state IDLE; new start afterward completes normally.

Source files
------------

// File: rtl/seq_divider_nr.sv
// seq_divider_nr: sequential radix-2 non-restoring integer divider.
// One quotient bit per clock; WIDTH+1 cycles from accepted start to done
// (1 cycle for divide-by-zero). Start/done handshake matches the sequential
// Booth multiplier.
// Build option: define SEQ_DIV_SIGNED_EN for signed two's-complement
// operation (quotient truncates toward zero, remainder takes the dividend's
// sign). Without it the divider is purely unsigned.
module seq_divider_nr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;        // signed partial remainder, one guard bit
    logic [WIDTH-1:0] q_q, q_d;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;        // divisor magnitude
    logic [WIDTH-1:0] dvd_q, dvd_d;    // raw dividend, returned as remainder on divide-by-zero
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1),
    // which still fits as a WIDTH-bit unsigned number.
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
`ifdef SEQ_DIV_SIGNED_EN
    assign mag_dvd = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    assign mag_dvd = dividend;
    assign mag_dvs = divisor;
`endif

    // One non-restoring step: shift {R,Q} left, then subtract D when the old
    // R is non-negative, add D otherwise. The true result always lies in
    // [-D, D), so WIDTH+1-bit modular arithmetic is exact.
    logic [WIDTH:0]   r_sh, r_new;
    logic [WIDTH-1:0] r_fix;
    assign r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_new = r_q[WIDTH] ? (r_sh + {1'b0, d_q}) : (r_sh - {1'b0, d_q});
    // Final correction: a negative remainder gets D added back once.
    assign r_fix = r_q[WIDTH-1:0] + (r_q[WIDTH] ? d_q : '0);

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    r_d     = '0;
                    q_d     = mag_dvd;
                    d_d     = mag_dvs;
                    dvd_d   = dividend;
                    count_d = CW'(WIDTH);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                    qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d  = dividend[WIDTH-1];
`endif
                    state_d = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                r_d     = r_new;
                q_d     = {q_q[WIDTH-2:0], ~r_new[WIDTH]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (d_q == '0) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                    dbz_d = 1'b1;
                end else begin
`ifdef SEQ_DIV_SIGNED_EN
                    quo_d = qneg_q ? -q_q : q_q;
                    rem_d = rneg_q ? -r_fix : r_fix;
`else
                    quo_d = q_q;
                    rem_d = r_fix;
`endif
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
